// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder bit per clock, LSB first, with a
// valid/ready handshake on both the operand and result sides.

module half_adder (
  input  logic x_i,
  input  logic y_i,
  output logic c_o,
  output logic s_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module or_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i | b_i;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               ha0_c, ha0_s;
  logic               ha1_c, fa_s, fa_c;
  logic [WIDTH-1:0]   sum_shift;
  logic               last_bit;

  half_adder u_ha0 (
    .x_i (a_sh_q[0]),
    .y_i (b_sh_q[0]),
    .c_o (ha0_c),
    .s_o (ha0_s)
  );

  half_adder u_ha1 (
    .x_i (ha0_s),
    .y_i (carry_q),
    .c_o (ha1_c),
    .s_o (fa_s)
  );

  or_gate u_or (
    .a_i (ha0_c),
    .b_i (ha1_c),
    .y_o (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign sum_shift = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_sh_d   = a;
          b_sh_d   = b;
          sum_sh_d = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shift;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        // Published result registers only change on the final bit edge.
        if (last_bit) begin
          sum_d   = sum_shift;
          c_out_d = fa_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = rst_n & (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Checks serial_adder at WIDTH=8, 4 and 1 against plain a+b arithmetic,
// including latency, backpressure, busy-ignore and mid-operation reset.

module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic        in_valid_t  [3];
  logic        out_ready_t [3];
  logic [31:0] a_t         [3];
  logic [31:0] b_t         [3];
  logic        in_ready_t  [3];
  logic        out_valid_t [3];
  logic        c_out_t     [3];
  logic [31:0] sum_t       [3];

  logic [7:0] sum8;
  logic [3:0] sum4;
  logic [0:0] sum1;

  int npass = 0;
  int ntot  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_t[0]),
    .in_ready  (in_ready_t[0]),
    .a         (a_t[0][7:0]),
    .b         (b_t[0][7:0]),
    .out_valid (out_valid_t[0]),
    .out_ready (out_ready_t[0]),
    .sum       (sum8),
    .c_out     (c_out_t[0])
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_t[1]),
    .in_ready  (in_ready_t[1]),
    .a         (a_t[1][3:0]),
    .b         (b_t[1][3:0]),
    .out_valid (out_valid_t[1]),
    .out_ready (out_ready_t[1]),
    .sum       (sum4),
    .c_out     (c_out_t[1])
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_t[2]),
    .in_ready  (in_ready_t[2]),
    .a         (a_t[2][0:0]),
    .b         (b_t[2][0:0]),
    .out_valid (out_valid_t[2]),
    .out_ready (out_ready_t[2]),
    .sum       (sum1),
    .c_out     (c_out_t[2])
  );

  assign sum_t[0] = 32'(sum8);
  assign sum_t[1] = 32'(sum4);
  assign sum_t[2] = 32'(sum1);

  function automatic int width_of(input int d);
    case (d)
      0:       return 8;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One complete transaction on DUT d; entered and left just after a negedge.
  task automatic do_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                       input int stall, input bit busy);
    int          w;
    logic [31:0] mask;
    logic [32:0] full;
    logic [31:0] es;
    logic        ec;
    int          cyc;
    w    = width_of(d);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, av & mask} + {1'b0, bv & mask};
    es   = full[31:0] & mask;
    ec   = full[w];

    cyc = 0;
    while (!in_ready_t[d] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("d%0d in_ready_idle", d), 32'(in_ready_t[d]), 32'd1);

    a_t[d]         = av;
    b_t[d]         = bv;
    in_valid_t[d]  = 1'b1;
    out_ready_t[d] = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    if (busy) begin
      a_t[d] = $urandom;
      b_t[d] = $urandom;
    end else begin
      in_valid_t[d] = 1'b0;
    end
    chk($sformatf("d%0d in_ready_busy", d), 32'(in_ready_t[d]), 32'd0);

    cyc = 0;
    while (!out_valid_t[d] && cyc < w + 4) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (busy) begin
        a_t[d] = $urandom;
        b_t[d] = $urandom;
      end
    end
    chk($sformatf("d%0d latency", d), 32'(cyc), 32'(w));
    chk($sformatf("d%0d sum a=%0h b=%0h", d, av, bv), sum_t[d], es);
    chk($sformatf("d%0d c_out a=%0h b=%0h", d, av, bv), 32'(c_out_t[d]), 32'(ec));

    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) begin
        a_t[d] = $urandom;
        b_t[d] = $urandom;
      end
      chk($sformatf("d%0d hold_valid", d), 32'(out_valid_t[d]), 32'd1);
      chk($sformatf("d%0d hold_sum", d), sum_t[d], es);
      chk($sformatf("d%0d hold_c_out", d), 32'(c_out_t[d]), 32'(ec));
      chk($sformatf("d%0d hold_in_ready", d), 32'(in_ready_t[d]), 32'd0);
    end

    out_ready_t[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_t[d]  = 1'b0;
    out_ready_t[d] = 1'b0;
    chk($sformatf("d%0d out_valid_drop", d), 32'(out_valid_t[d]), 32'd0);
    chk($sformatf("d%0d in_ready_back", d), 32'(in_ready_t[d]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", npass, ntot);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_t[d]  = 1'b0;
      out_ready_t[d] = 1'b0;
      a_t[d]         = '0;
      b_t[d]         = '0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready_t[0]), 32'd0);
    chk("rst out_valid", 32'(out_valid_t[0]), 32'd0);
    chk("rst sum", sum_t[0], 32'd0);
    chk("rst c_out", 32'(c_out_t[0]), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst release in_ready", 32'(in_ready_t[0]), 32'd1);

    do_op(0, 32'h5A, 32'h3C, 0, 1'b0);
    do_op(0, 32'hFF, 32'h01, 0, 1'b0);
    do_op(0, 32'hFF, 32'hFF, 0, 1'b0);
    do_op(0, 32'h00, 32'h00, 0, 1'b0);
    do_op(0, 32'h12, 32'h34, 5, 1'b0);
    do_op(0, 32'hC3, 32'h7E, 2, 1'b1);

    a_t[0]         = 32'hA7;
    b_t[0]         = 32'h6B;
    in_valid_t[0]  = 1'b1;
    out_ready_t[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_t[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst in_ready", 32'(in_ready_t[0]), 32'd0);
    chk("midrst out_valid", 32'(out_valid_t[0]), 32'd0);
    chk("midrst sum", sum_t[0], 32'd0);
    chk("midrst c_out", 32'(c_out_t[0]), 32'd0);
    rst_n          = 1'b1;
    out_ready_t[0] = 1'b0;
    #1;
    chk("midrst release in_ready", 32'(in_ready_t[0]), 32'd1);
    do_op(0, 32'h01, 32'h02, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_op(0, $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        do_op(1, 32'(av), 32'(bv), int'($urandom_range(0, 2)), 1'b0);
      end
    end

    for (int av = 0; av < 2; av++) begin
      for (int bv = 0; bv < 2; bv++) begin
        do_op(2, 32'(av), 32'(bv), int'($urandom_range(0, 2)), 1'b0);
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
